tdm_demux: RTL

- Receiving end of the 2:1 bit-interleaved serial link that the datapath mux feeds.
- Takes one serial bit stream that alternates channel 0 / channel 1 bit by bit, MSB first, and rebuilds two parallel WIDTH-bit words.
- Channel tracking is a Moore FSM. Output `sel` mirrors the select the transmitting mux used, so it can drive downstream debug or loopback logic.

---
 rtl/tdm_pkg.sv | 11 +
 rtl/tdm_demux_shift_in_reg.sv | 15 +
 rtl/tdm_demux.sv | 69 ++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and sizing helper for the TDM demux
package tdm_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX_0 = 2'd1,
    ST_RX_1 = 2'd2
  } state_t;
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction
endpackage

// File: rtl/tdm_demux_shift_in_reg.sv
// shift_in_reg: serial-in/parallel-out register, MSB-first; clr restarts it with the current bit
module shift_in_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else q <= clr ? {{(WIDTH-1){1'b0}}, sin & shift_en} : shift_en ? {q[WIDTH-2:0], sin} : q;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: rebuilds two WIDTH-bit words from a bit-interleaved 2:1 serial stream
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame,
  output logic [WIDTH-1:0] dout_0,
  output logic [WIDTH-1:0] dout_1,
  output logic             dout_valid,
  output logic             sel,
  output logic             sync_err
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] q0, q1;
  logic start;
  assign start = din_valid & frame;
  shift_in_reg #(.WIDTH(WIDTH)) u_ch0 (
    .clk(clk), .reset(reset),
    .shift_en(din_valid & (frame | state == ST_RX_0)),
    .clr(start), .sin(din), .q(q0)
  );
  shift_in_reg #(.WIDTH(WIDTH)) u_ch1 (
    .clk(clk), .reset(reset),
    .shift_en(din_valid & ~frame & state == ST_RX_1),
    .clr(start), .sin(din), .q(q1)
  );
  // ch1's final bit is still on din at completion, so it is spliced in directly
  always_ff @(posedge clk)
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dout_0     <= '0;
      dout_1     <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      sel        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      if (start) begin
        sync_err <= state != ST_IDLE;
        cnt      <= '0;
        state    <= ST_RX_1;
        sel      <= 1'b1;
      end else if (din_valid && state == ST_RX_0) begin
        state <= ST_RX_1;
        sel   <= 1'b1;
      end else if (din_valid && state == ST_RX_1) begin
        sel <= 1'b0;
        if (cnt == LAST) begin
          dout_0     <= q0;
          dout_1     <= {q1[WIDTH-2:0], din};
          dout_valid <= 1'b1;
          state      <= ST_IDLE;
        end else begin
          cnt   <= cnt + 1'b1;
          state <= ST_RX_0;
        end
      end
    end
endmodule
